// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny frame sequencer and its address generator.
package canny_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } seq_state_t;

  localparam int DEF_IMG_W = 512;
  localparam int DEF_IMG_H = 512;
  localparam int PIXEL_W   = 8;
  localparam int OUT_CNT_W = 20;

  function automatic int total_pixels(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/canny_raster_addr_gen.sv
// Raster-order read address generator: clears to 0, advances on each issued read,
// and parks on the last pixel of the frame instead of wrapping.
module canny_raster_addr_gen
  import canny_pkg::*;
#(
  parameter int TOTAL  = total_pixels(DEF_IMG_W, DEF_IMG_H),
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              clr_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              last_pixel_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    addr_d = addr_q;
    if (clr_i) begin
      addr_d = '0;
    end else if (en_i && !last_pixel_o) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  // NOTE: registers use <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign mem_addr_o   = addr_q;
  assign last_pixel_o = (addr_q == LAST_ADDR);

endmodule

// File: rtl/canny_frame_sequencer.sv
// Frame sequencer feeding one raster-order frame into the Canny pipeline and counting results.
// Optional SEQ_PERF_CNT_EN adds the frame_cycles start-to-DONE cycle counter output.
module canny_frame_sequencer
  import canny_pkg::*;
#(
  parameter int IMG_W         = DEF_IMG_W,
  parameter int IMG_H         = DEF_IMG_H,
  parameter int EXP_OUT       = 254016,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int ADDR_W        = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stall,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [PIXEL_W-1:0]   mem_rdata,
  output logic [PIXEL_W-1:0]   pixel_out,
  output logic                 pixel_out_valid,
  input  logic                 result_valid,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 timeout_err,
  output logic [OUT_CNT_W-1:0] out_count
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]          frame_cycles
`endif
);

  localparam int TOTAL  = total_pixels(IMG_W, IMG_H);
  localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [OUT_CNT_W-1:0] EXP_CNT    = OUT_CNT_W'(EXP_OUT);
  localparam logic [IDLE_W-1:0]    IDLE_LIMIT = IDLE_W'(DRAIN_TIMEOUT);

  seq_state_t state_q, state_d;
  logic last_pixel, start_acc, count_hit, idle_hit;
  logic [OUT_CNT_W-1:0] out_count_q, out_count_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic pixel_valid_q, frame_done_q, timeout_q;

  canny_raster_addr_gen #(
    .TOTAL (TOTAL),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .en_i        (mem_rd_en),
    .clr_i       (start_acc),
    .mem_addr_o  (mem_addr),
    .last_pixel_o(last_pixel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    out_count_d = out_count_q;
    if (start_acc) begin
      out_count_d = '0;
    end else if (result_valid && busy && (out_count_q != '1)) begin
      out_count_d = out_count_q + OUT_CNT_W'(1);
    end
    idle_d = '0;
    if ((state_q == DRAIN) && !result_valid) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  // Completion looks at the count including this cycle's beat, so DONE and the final count coincide.
  assign count_hit = (out_count_d >= EXP_CNT);
  assign idle_hit  = (idle_d == IDLE_LIMIT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = FETCH;
      FETCH:      if (mem_rd_en && last_pixel) state_d = DRAIN;
      DRAIN:      if (count_hit || idle_hit) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = (state_q == FETCH) && !stall;
    busy      = (state_q == FETCH) || (state_q == DRAIN);
    start_acc = start && ((state_q == IDLE) || (state_q == DONE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_count_q   <= '0;
      idle_q        <= '0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      out_count_q   <= out_count_d;
      idle_q        <= idle_d;
      pixel_valid_q <= mem_rd_en;
      frame_done_q  <= (state_q == DRAIN) && count_hit;
      if (start_acc) begin
        timeout_q <= 1'b0;
      end else if ((state_q == DRAIN) && !count_hit && idle_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign pixel_out_valid = pixel_valid_q;
  assign pixel_out       = pixel_valid_q ? mem_rdata : '0;
  assign frame_done      = frame_done_q;
  assign timeout_err     = timeout_q;
  assign out_count       = out_count_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_q <= '0;
    end else if (start_acc) begin
      cycles_q <= '0;
    end else if (busy && (cycles_q != '1)) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign frame_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_canny_frame_sequencer.sv
// Self-checking bench for canny_frame_sequencer on an 8x8 frame: a transaction-level model
// (reads issued, results counted, idle run) predicts every output each cycle.
module tb_canny_frame_sequencer;

  localparam int W     = 8;
  localparam int H     = 8;
  localparam int TOTAL = W * H;
  localparam int EXP   = 16;
  localparam int TO    = 32;
  localparam int AW    = 6;

  logic clk = 1'b0;
  logic rst, start, stall, result_valid;
  logic mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] pixel_out;
  logic pixel_out_valid, busy, frame_done, timeout_err;
  logic [19:0] out_count;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] frame_cycles;
`endif

  canny_frame_sequencer #(
    .IMG_W(W), .IMG_H(H), .EXP_OUT(EXP), .DRAIN_TIMEOUT(TO), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pixel_out(pixel_out), .pixel_out_valid(pixel_out_valid), .result_valid(result_valid),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err), .out_count(out_count)
`ifdef SEQ_PERF_CNT_EN
    , .frame_cycles(frame_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Image RAM with one cycle of read latency.
  logic [7:0] ram [TOTAL];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: what the frame has done so far, in plain counts.
  bit m_active, m_pend, m_done, m_to, exp_rd, drain, chk_en;
  int m_issued, m_count, m_idle, m_cycles, m_pend_addr;

  // Per-frame monitors read by the directed checks.
  int cyc, rd_cycles, first_rd, last_rd, first_rd_addr, pv_beats, done_pulses, busy_cycles;
  int start_cyc, first_pv;

  always @(negedge clk) begin
    cyc++;
    exp_rd = m_active && (m_issued < TOTAL) && !stall;
    if (chk_en) begin
      check("mem_rd_en", 32'(mem_rd_en), 32'(exp_rd));
      if (exp_rd) check("mem_addr", 32'(mem_addr), m_issued);
      check("pixel_out_valid", 32'(pixel_out_valid), 32'(m_pend));
      check("pixel_out", 32'(pixel_out), m_pend ? 32'(ram[m_pend_addr]) : 32'd0);
      check("busy", 32'(busy), 32'(m_active));
      check("frame_done", 32'(frame_done), 32'(m_done));
      check("timeout_err", 32'(timeout_err), 32'(m_to));
      check("out_count", 32'(out_count), m_count);
`ifdef SEQ_PERF_CNT_EN
      check("frame_cycles", frame_cycles, m_cycles);
`endif
      if (mem_rd_en) begin
        if (rd_cycles == 0) begin
          first_rd = cyc;
          first_rd_addr = int'(mem_addr);
        end
        last_rd = cyc;
        rd_cycles++;
      end
      if (pixel_out_valid) begin
        if (first_pv < 0) first_pv = cyc;
        pv_beats++;
      end
      if (frame_done) done_pulses++;
      if (busy) busy_cycles++;
      if (start && !rst && !m_active) start_cyc = cyc;
    end
    if (rst) begin
      m_active = 0; m_issued = 0; m_count = 0; m_idle = 0; m_cycles = 0;
      m_pend = 0; m_pend_addr = 0; m_done = 0; m_to = 0;
    end else begin
      drain = m_active && (m_issued == TOTAL);
      m_pend = exp_rd;
      m_pend_addr = m_issued;
      m_done = 0;
      if (m_active) begin
        if (exp_rd) m_issued++;
        if (result_valid && m_count < 20'hFFFFF) m_count++;
        m_cycles++;
        if (drain) begin
          if (m_count >= EXP) begin
            m_active = 0;
            m_done = 1;
          end else begin
            m_idle = result_valid ? 0 : m_idle + 1;
            if (m_idle == TO) begin
              m_active = 0;
              m_to = 1;
            end
          end
        end
      end else if (start) begin
        m_active = 1; m_issued = 0; m_count = 0; m_idle = 0; m_cycles = 0; m_to = 0;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One frame: start pulse, then results/stalls/spurious starts until busy drops.
  task automatic run_frame(input int n_res, input int res_start, input int stall_addr,
                           input int stall_len, input bit rnd, input bit spur);
    int sent = 0;
    int stall_left = 0;
    bit stalled = 0;
    for (int i = 0; i < TOTAL; i++) ram[i] = 8'($urandom);
    rd_cycles = 0; pv_beats = 0; done_pulses = 0; busy_cycles = 0; first_pv = -1;
    start = 1;
    cycle();
    start = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!busy) break;
      result_valid = 0;
      if (sent < n_res && n >= res_start && (!rnd || $urandom_range(0, 2) == 0)) begin
        result_valid = 1;
        sent++;
      end
      if (rnd) begin
        stall = ($urandom_range(0, 3) == 0);
      end else begin
        if (!stalled && int'(mem_addr) == stall_addr) begin
          stall_left = stall_len;
          stalled = 1;
        end
        stall = (stall_left > 0);
        if (stall_left > 0) stall_left--;
      end
      start = (spur && (n == 30 || n == 75)) || (rnd && $urandom_range(0, 39) == 0);
      cycle();
    end
    result_valid = 0; stall = 0; start = 0;
    check("frame_end_busy", 32'(busy), 32'd0);
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; stall = 0; result_valid = 0;
    chk_en = 0; cyc = 0; first_pv = -1;
    for (int i = 0; i < TOTAL; i++) ram[i] = 8'($urandom);
    cycle();
    start = 1;
    cycle();
    start = 0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_pv", 32'(pixel_out_valid), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    chk_en = 1;
    rst = 0;

    // Result beats in IDLE are ignored.
    result_valid = 1;
    repeat (3) cycle();
    result_valid = 0;
    cycle();
    check("idle_beats_ignored", 32'(out_count), 32'd0);

    // Clean frame, results returned early during FETCH.
    run_frame(16, 5, -1, 0, 0, 0);
    check("f1_first_pv_latency", first_pv - start_cyc, 32'd2);
    check("f1_rd_cycles", rd_cycles, 32'd64);
    check("f1_rd_contiguous", last_rd - first_rd + 1, 32'd64);
    check("f1_first_addr", first_rd_addr, 32'd0);
    check("f1_pixel_beats", pv_beats, 32'd64);
    check("f1_done_pulses", done_pulses, 32'd1);
    check("f1_out_count", 32'(out_count), 32'd16);
    check("f1_busy_cycles", busy_cycles, 32'd65);
`ifdef SEQ_PERF_CNT_EN
    check("f1_frame_cycles", frame_cycles, 32'd65);
    repeat (3) cycle();
    check("f1_frame_cycles_hold", frame_cycles, 32'd65);
`endif

    // Back-to-back start from DONE, with a 3-cycle stall at address 10.
    run_frame(16, 5, 10, 3, 0, 0);
    check("f2_rd_cycles", rd_cycles, 32'd64);
    check("f2_pixel_beats", pv_beats, 32'd64);
    check("f2_busy_cycles", busy_cycles, 32'd68);
    check("f2_done_pulses", done_pulses, 32'd1);

    // Only 15 results: timeout after 32 idle DRAIN cycles; starts in FETCH and DRAIN ignored.
    run_frame(15, 5, -1, 0, 0, 1);
    check("f3_done_pulses", done_pulses, 32'd0);
    check("f3_timeout", 32'(timeout_err), 32'd1);
    check("f3_rd_cycles", rd_cycles, 32'd64);
    check("f3_busy_cycles", busy_cycles, 32'd96);
    check("f3_out_count", 32'(out_count), 32'd15);

    // Next start clears the sticky timeout.
    run_frame(16, 5, -1, 0, 0, 0);
    check("f4_timeout_cleared", 32'(timeout_err), 32'd0);
    check("f4_done_pulses", done_pulses, 32'd1);

    // Reset in the middle of FETCH at address 20.
    start = 1;
    cycle();
    start = 0;
    result_valid = 1;
    for (int n = 0; n < 200; n++) begin
      if (mem_addr == AW'(20)) break;
      cycle();
    end
    check("reach_addr20", 32'(mem_addr), 32'd20);
    rst = 1;
    result_valid = 0;
    cycle();
    rst = 0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_pv", 32'(pixel_out_valid), 32'd0);
    check("mid_rst_pixel", 32'(pixel_out), 32'd0);
    check("mid_rst_count", 32'(out_count), 32'd0);
    check("mid_rst_done", 32'(frame_done), 32'd0);
    cycle();
    run_frame(16, 5, -1, 0, 0, 0);
    check("f5_first_addr", first_rd_addr, 32'd0);
    check("f5_done_pulses", done_pulses, 32'd1);

    // Randomized frames: random stalls, result timing, result totals and spurious starts.
    for (int f = 0; f < 8; f++) begin
      run_frame($urandom_range(12, 24), $urandom_range(0, 30), -1, 0, 1, 0);
      check("rnd_pixel_beats", pv_beats, 32'd64);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
